// File: rtl/memp_pkg.sv
// Shared constants and types for the P-vector memory row packer.
// Elements pack into rows with lane 0 at the LSBs.
package memp_pkg;

  localparam int ELEMENT_WIDTH  = 64;
  localparam int NO_OF_UNITS    = 8;
  localparam int MEM_ADDR_WIDTH = 20;
  localparam int MEM_DEPTH      = 1001;
  localparam int LANE_W         = $clog2(NO_OF_UNITS);
  localparam int ROW_W          = NO_OF_UNITS * ELEMENT_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } packer_state_t;

  typedef logic [ROW_W-1:0] row_t;

  // The end row is computed one bit wider so that a base near the top of the
  // address space cannot wrap around and pass the check.
  function automatic logic range_ok(input logic [MEM_ADDR_WIDTH-1:0] base,
                                    input logic [MEM_ADDR_WIDTH-1:0] rows);
    logic [MEM_ADDR_WIDTH:0] end_row;
    end_row = {1'b0, base} + {1'b0, rows};
    return end_row <= (MEM_ADDR_WIDTH+1)'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/memp_row_packer_if.sv
// Element stream in, wide row write out, for the P-vector memory packer.
interface memp_row_packer_if
  import memp_pkg::*;
();

  logic                      in_valid;
  logic [ELEMENT_WIDTH-1:0]  in_data;
  logic                      in_ready;
  row_t                      mem_write_data;
  logic                      mem_write_enable;
  logic [MEM_ADDR_WIDTH-1:0] mem_write_address;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_write_data, mem_write_enable, mem_write_address
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_write_data, mem_write_enable, mem_write_address
  );

endinterface

// File: rtl/memp_row_packer.sv
// Packs NO_OF_UNITS consecutive P elements into one wide row and issues one
// registered write per completed row, filling row_count rows from base_address.
module memp_row_packer
  import memp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_address,
  input  logic [MEM_ADDR_WIDTH-1:0] row_count,
  memp_row_packer_if.slave          bus,
  output logic                      busy,
  output logic                      finish,
  output logic                      range_err
);

  packer_state_t state_q, state_d;

  logic [LANE_W-1:0]         lane_q;
  logic [MEM_ADDR_WIDTH-1:0] row_q;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [MEM_ADDR_WIDTH-1:0] rows_q;

  logic [ELEMENT_WIDTH-1:0]                 lanes_p0 [NO_OF_UNITS-1];
  logic [(NO_OF_UNITS-1)*ELEMENT_WIDTH-1:0] lanes_flat_p0;

  logic accept;
  logic lane_last;
  logic row_done;
  logic job_last;
  logic load_job;
  logic fin_d;
  logic rerr_d;

  assign accept    = (state_q == FILL) && bus.in_valid;
  assign lane_last = (lane_q == LANE_W'(NO_OF_UNITS-1));
  assign row_done  = accept && lane_last;
  assign job_last  = row_done && (row_q == rows_q - 1'b1);

  always_comb begin
    lanes_flat_p0 = '0;
    for (int i = 0; i < NO_OF_UNITS-1; i++) begin
      lanes_flat_p0[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = lanes_p0[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    bus.in_ready = 1'b0;
    load_job     = 1'b0;
    fin_d        = 1'b0;
    rerr_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (row_count == '0) begin
            state_d = DONE;
          end else if (!range_ok(base_address, row_count)) begin
            rerr_d = 1'b1;
          end else begin
            load_job = 1'b1;
            state_d  = FILL;
          end
        end
      end
      FILL: begin
        busy         = 1'b1;
        bus.in_ready = 1'b1;
        if (job_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        fin_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job control, lane/row counters and one-cycle strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q               <= '0;
      row_q                <= '0;
      base_q               <= '0;
      rows_q               <= '0;
      finish               <= 1'b0;
      range_err            <= 1'b0;
      bus.mem_write_enable <= 1'b0;
    end else begin
      finish               <= fin_d;
      range_err            <= rerr_d;
      bus.mem_write_enable <= row_done;
      if (load_job) begin
        base_q <= base_address;
        rows_q <= row_count;
        lane_q <= '0;
        row_q  <= '0;
      end else if (accept) begin
        lane_q <= lane_last ? '0 : lane_q + LANE_W'(1);
        if (lane_last) begin
          row_q <= row_q + 1'b1;
        end
      end
    end
  end

  // p0: lane capture; p1: the final element is merged straight into the
  // registered row so a write issues without a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NO_OF_UNITS-1; i++) begin
        lanes_p0[i] <= '0;
      end
      bus.mem_write_data    <= '0;
      bus.mem_write_address <= '0;
    end else if (accept) begin
      if (lane_last) begin
        bus.mem_write_data    <= {bus.in_data, lanes_flat_p0};
        bus.mem_write_address <= base_q + row_q;
      end else begin
        lanes_p0[lane_q] <= bus.in_data;
      end
    end
  end

endmodule
